// File: rtl/vga_timing_pkg.sv
// Default VGA 640x480 raster timing, derived totals and the RGB565 colour-bar palette
// shared by the timing generator and the FIFO reader.
package vga_timing_pkg;
   localparam int CLK_DIV_DEF  = 4;
   localparam int H_ACTIVE_DEF = 640;
   localparam int H_FP_DEF     = 16;
   localparam int H_SYNC_DEF   = 96;
   localparam int H_BP_DEF     = 48;
   localparam int V_ACTIVE_DEF = 480;
   localparam int V_FP_DEF     = 10;
   localparam int V_SYNC_DEF   = 2;
   localparam int V_BP_DEF     = 33;
   localparam int H_TOTAL_DEF  = H_ACTIVE_DEF + H_FP_DEF + H_SYNC_DEF + H_BP_DEF;
   localparam int V_TOTAL_DEF  = V_ACTIVE_DEF + V_FP_DEF + V_SYNC_DEF + V_BP_DEF;

   localparam logic [15:0] RGB_WHITE   = 16'hFFFF;
   localparam logic [15:0] RGB_YELLOW  = 16'hFFE0;
   localparam logic [15:0] RGB_CYAN    = 16'h07FF;
   localparam logic [15:0] RGB_GREEN   = 16'h07E0;
   localparam logic [15:0] RGB_MAGENTA = 16'hF81F;
   localparam logic [15:0] RGB_RED     = 16'hF800;
   localparam logic [15:0] RGB_BLUE    = 16'h001F;
   localparam logic [15:0] RGB_BLACK   = 16'h0000;

   function automatic logic [15:0] bar_colour(input logic [2:0] idx);
      case (idx)
         3'd0:    return RGB_WHITE;
         3'd1:    return RGB_YELLOW;
         3'd2:    return RGB_CYAN;
         3'd3:    return RGB_GREEN;
         3'd4:    return RGB_MAGENTA;
         3'd5:    return RGB_RED;
         3'd6:    return RGB_BLUE;
         default: return RGB_BLACK;
      endcase
   endfunction
endpackage

// File: rtl/vga_timing_gen.sv
// Pixel clock-enable divider plus horizontal/vertical raster counters with
// active-area and sync-region decode.
module vga_timing_gen
   import vga_timing_pkg::*;
#(
   parameter int CLK_DIV  = CLK_DIV_DEF,
   parameter int H_ACTIVE = H_ACTIVE_DEF,
   parameter int H_FP     = H_FP_DEF,
   parameter int H_SYNC   = H_SYNC_DEF,
   parameter int H_BP     = H_BP_DEF,
   parameter int V_ACTIVE = V_ACTIVE_DEF,
   parameter int V_FP     = V_FP_DEF,
   parameter int V_SYNC   = V_SYNC_DEF,
   parameter int V_BP     = V_BP_DEF
) (
   input  logic        clk_100M,
   input  logic        rst_100i,
   output logic        pix_ce,
   output logic [10:0] h_cnt,
   output logic [9:0]  v_cnt,
   output logic        active,
   output logic        hs_region,
   output logic        vs_region
);
   localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
   localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

   localparam logic [3:0]  DIV_LAST = 4'(CLK_DIV - 1);
   localparam logic [10:0] H_LAST   = 11'(H_TOTAL - 1);
   localparam logic [9:0]  V_LAST   = 10'(V_TOTAL - 1);
   localparam logic [10:0] H_ACT    = 11'(H_ACTIVE);
   localparam logic [9:0]  V_ACT    = 10'(V_ACTIVE);
   localparam logic [10:0] HS_START = 11'(H_ACTIVE + H_FP);
   localparam logic [10:0] HS_END   = 11'(H_ACTIVE + H_FP + H_SYNC);
   localparam logic [9:0]  VS_START = 10'(V_ACTIVE + V_FP);
   localparam logic [9:0]  VS_END   = 10'(V_ACTIVE + V_FP + V_SYNC);

   logic [3:0] div_cnt;

   // Gated by reset so no pop or frame pulse can leak out while held in reset.
   assign pix_ce    = rst_100i && (div_cnt == DIV_LAST);
   assign active    = (h_cnt < H_ACT) && (v_cnt < V_ACT);
   assign hs_region = (h_cnt >= HS_START) && (h_cnt < HS_END);
   assign vs_region = (v_cnt >= VS_START) && (v_cnt < VS_END);

   always_ff @(posedge clk_100M) begin
      if (!rst_100i) begin
         div_cnt <= '0;
         h_cnt   <= '0;
         v_cnt   <= '0;
      end else begin
         div_cnt <= (div_cnt == DIV_LAST) ? 4'd0 : div_cnt + 4'd1;
         if (pix_ce) begin
            if (h_cnt == H_LAST) begin
               h_cnt <= '0;
               v_cnt <= (v_cnt == V_LAST) ? 10'd0 : v_cnt + 10'd1;
            end else begin
               h_cnt <= h_cnt + 11'd1;
            end
         end
      end
   end
endmodule

// File: rtl/vga_fifo_reader.sv
// VGA display-side FIFO consumer: pops one RGB565 word per active pixel and drives sync/DE/RGB.
// Build option VGA_TESTPAT_EN adds a test_mode colour-bar source that bypasses the FIFO.
module vga_fifo_reader
   import vga_timing_pkg::*;
#(
   parameter int CLK_DIV  = CLK_DIV_DEF,
   parameter int H_ACTIVE = H_ACTIVE_DEF,
   parameter int H_FP     = H_FP_DEF,
   parameter int H_SYNC   = H_SYNC_DEF,
   parameter int H_BP     = H_BP_DEF,
   parameter int V_ACTIVE = V_ACTIVE_DEF,
   parameter int V_FP     = V_FP_DEF,
   parameter int V_SYNC   = V_SYNC_DEF,
   parameter int V_BP     = V_BP_DEF
) (
   input  logic        clk_100M,
   input  logic        rst_100i,
   input  logic [15:0] data_vga,
   input  logic        fifo_rdempty,
   input  logic        test_mode,
   output logic        vga_rdfifo,
   output logic        vga_hs,
   output logic        vga_vs,
   output logic        vga_de,
   output logic [15:0] vga_rgb,
   output logic        frame_start,
   output logic        underflow_o
);
   logic        pix_ce, active, hs_region, vs_region;
   logic [10:0] h_cnt;
   logic [9:0]  v_cnt;
   logic        tp_sel;
   logic [15:0] tp_rgb;

   vga_timing_gen #(
      .CLK_DIV(CLK_DIV), .H_ACTIVE(H_ACTIVE), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
      .V_ACTIVE(V_ACTIVE), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP)
   ) u_timing (
      .clk_100M (clk_100M),
      .rst_100i (rst_100i),
      .pix_ce   (pix_ce),
      .h_cnt    (h_cnt),
      .v_cnt    (v_cnt),
      .active   (active),
      .hs_region(hs_region),
      .vs_region(vs_region)
   );

`ifdef VGA_TESTPAT_EN
   logic [2:0] bar_idx;
   assign bar_idx = 3'((int'(h_cnt) * 8) / H_ACTIVE);
   assign tp_sel  = test_mode;
   assign tp_rgb  = bar_colour(bar_idx);
`else
   logic unused_test_mode;
   assign unused_test_mode = test_mode;
   assign tp_sel = 1'b0;
   assign tp_rgb = 16'h0000;
`endif

   logic pop, starve;
   assign pop         = pix_ce && active && !fifo_rdempty && !tp_sel;
   assign starve      = pix_ce && active && fifo_rdempty && !tp_sel;
   assign vga_rdfifo  = pop;
   assign frame_start = pix_ce && (h_cnt == 11'd0) && (v_cnt == 10'd0);

   // Pixel attributes wait one clk in this stage so they meet the FIFO read data.
   logic        ce_d, pop_d, act_d, hs_d, vs_d, tp_d;
   logic [15:0] tp_rgb_d;

   always_ff @(posedge clk_100M) begin
      if (!rst_100i) begin
         ce_d        <= 1'b0;
         pop_d       <= 1'b0;
         act_d       <= 1'b0;
         hs_d        <= 1'b1;
         vs_d        <= 1'b1;
         tp_d        <= 1'b0;
         tp_rgb_d    <= '0;
         vga_hs      <= 1'b1;
         vga_vs      <= 1'b1;
         vga_de      <= 1'b0;
         vga_rgb     <= '0;
         underflow_o <= 1'b0;
      end else begin
         ce_d <= pix_ce;
         if (pix_ce) begin
            pop_d    <= pop;
            act_d    <= active;
            hs_d     <= !hs_region;
            vs_d     <= !vs_region;
            tp_d     <= tp_sel;
            tp_rgb_d <= tp_rgb;
         end
         if (ce_d) begin
            vga_hs <= hs_d;
            vga_vs <= vs_d;
            vga_de <= act_d;
            if (!act_d)
               vga_rgb <= '0;
            else if (pop_d)
               vga_rgb <= data_vga;
            else if (tp_d)
               vga_rgb <= tp_rgb_d;
            else
               vga_rgb <= '0;
         end
         // A starve on pixel (0,0) must survive the frame-start clear.
         if (starve)
            underflow_o <= 1'b1;
         else if (frame_start)
            underflow_o <= 1'b0;
      end
   end
endmodule

// File: tb/tb_vga_fifo_reader.sv
// Directed bench for vga_fifo_reader using a reduced raster (14x7 totals, 8x4 active, CLK_DIV=2).
module tb_vga_fifo_reader;
   localparam int H_TOT = 14;
   localparam int V_TOT = 7;
   localparam int F_PIX = H_TOT * V_TOT;

   logic        clk_100M = 1'b0;
   logic        rst_100i = 1'b0;
   logic [15:0] data_vga = 16'h0000;
   logic        fifo_rdempty = 1'b0;
   logic        test_mode = 1'b0;
   logic        vga_rdfifo, vga_hs, vga_vs, vga_de, frame_start, underflow_o;
   logic [15:0] vga_rgb;

   int          checks = 0;
   int          errors = 0;
   int          force_h = -1;
   int          force_v = -1;
   logic [15:0] next_val = 16'h0001;
   bit          exp_uf = 1'b0;
   bit          tp_on = 1'b0;
   logic [15:0] fifo_q[$];

   vga_fifo_reader #(
      .CLK_DIV(2), .H_ACTIVE(8), .H_FP(2), .H_SYNC(2), .H_BP(2),
      .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(1)
   ) dut (
      .clk_100M    (clk_100M),
      .rst_100i    (rst_100i),
      .data_vga    (data_vga),
      .fifo_rdempty(fifo_rdempty),
      .test_mode   (test_mode),
      .vga_rdfifo  (vga_rdfifo),
      .vga_hs      (vga_hs),
      .vga_vs      (vga_vs),
      .vga_de      (vga_de),
      .vga_rgb     (vga_rgb),
      .frame_start (frame_start),
      .underflow_o (underflow_o)
   );

   always #5 clk_100M = ~clk_100M;

   // Read data appears the clk after rdreq, like a non-showahead FIFO.
   always @(posedge clk_100M)
      if (vga_rdfifo && fifo_q.size() > 0)
         data_vga <= fifo_q.pop_front();

   function automatic bit forced(input int p);
      int q;
      q = p % F_PIX;
      return ((q % H_TOT) == force_h) && ((q / H_TOT) == force_v);
   endfunction

   function automatic logic [15:0] bar_ref(input int h);
      case (h)
         0: return 16'hFFFF;
         1: return 16'hFFE0;
         2: return 16'h07FF;
         3: return 16'h07E0;
         4: return 16'hF81F;
         5: return 16'hF800;
         6: return 16'h001F;
         default: return 16'h0000;
      endcase
   endfunction

   // Entered at the negedge of the pix_ce clk of raster pixel 0; leaves at pixel npix.
   task automatic run_pixels(input string tag, input int npix);
      for (int p = 0; p < npix; p++) begin
         int h, v;
         bit act, emp;
         logic exp_pop, exp_hs, exp_vs;
         logic [15:0] exp_rgb;
         h = p % H_TOT;
         v = (p / H_TOT) % V_TOT;
         act = (h < 8) && (v < 4);
         emp = forced(p);
         exp_pop = act && !emp && !tp_on;
         checks++;
         if (frame_start !== ((p % F_PIX) == 0)) begin
            errors++;
            $display("FAIL %s frame_start h=%0d v=%0d got %b exp %b", tag, h, v, frame_start, (p % F_PIX) == 0);
         end
         checks++;
         if (vga_rdfifo !== exp_pop) begin
            errors++;
            $display("FAIL %s rdfifo h=%0d v=%0d got %b exp %b", tag, h, v, vga_rdfifo, exp_pop);
         end
         @(negedge clk_100M);
         if ((p % F_PIX) == 0) exp_uf = 1'b0;
         if (act && emp && !tp_on) exp_uf = 1'b1;
         checks++;
         if (underflow_o !== exp_uf) begin
            errors++;
            $display("FAIL %s underflow h=%0d v=%0d got %b exp %b", tag, h, v, underflow_o, exp_uf);
         end
         fifo_rdempty = forced(p + 1);
         @(negedge clk_100M);
         exp_hs = !((h >= 10) && (h < 12));
         exp_vs = !(v == 5);
         if (!act)
            exp_rgb = 16'h0000;
         else if (tp_on)
            exp_rgb = bar_ref(h);
         else if (emp)
            exp_rgb = 16'h0000;
         else begin
            exp_rgb = next_val;
            next_val = next_val + 16'd1;
         end
         checks++;
         if (vga_de !== act || vga_hs !== exp_hs || vga_vs !== exp_vs) begin
            errors++;
            $display("FAIL %s timing h=%0d v=%0d got de/hs/vs %b%b%b exp %b%b%b",
                     tag, h, v, vga_de, vga_hs, vga_vs, act, exp_hs, exp_vs);
         end
         checks++;
         if (vga_rgb !== exp_rgb) begin
            errors++;
            $display("FAIL %s rgb h=%0d v=%0d got %h exp %h", tag, h, v, vga_rgb, exp_rgb);
         end
      end
   endtask

   task automatic check_reset_outputs(input string tag);
      checks++;
      if (vga_hs !== 1'b1 || vga_vs !== 1'b1 || vga_de !== 1'b0 || vga_rgb !== 16'h0000 ||
          vga_rdfifo !== 1'b0 || frame_start !== 1'b0 || underflow_o !== 1'b0) begin
         errors++;
         $display("FAIL %s got hs=%b vs=%b de=%b rgb=%h rd=%b fs=%b uf=%b exp 1 1 0 0000 0 0 0",
                  tag, vga_hs, vga_vs, vga_de, vga_rgb, vga_rdfifo, frame_start, underflow_o);
      end
   endtask

   task automatic test_reset();
      repeat (5) begin
         @(negedge clk_100M);
         check_reset_outputs("reset_hold");
      end
      rst_100i = 1'b1;
      #1;
      checks++;
      if (frame_start !== 1'b0) begin
         errors++;
         $display("FAIL reset_release frame_start got %b exp 0", frame_start);
      end
      @(negedge clk_100M);
      exp_uf = 1'b0;
   endtask

   task automatic test_raster();
      run_pixels("raster", F_PIX);
   endtask

   task automatic test_underflow();
      force_h = 3;
      force_v = 1;
      run_pixels("underflow", F_PIX);
      force_h = -1;
      force_v = -1;
      run_pixels("uf_clear", F_PIX);
   endtask

   task automatic test_reset_midframe();
      run_pixels("pre_reset", 2 * H_TOT + 5);
      rst_100i = 1'b0;
      #1;
      checks++;
      if (vga_rdfifo !== 1'b0) begin
         errors++;
         $display("FAIL midreset rdfifo got %b exp 0", vga_rdfifo);
      end
      @(negedge clk_100M);
      check_reset_outputs("midreset");
      @(negedge clk_100M);
      check_reset_outputs("midreset_hold");
      rst_100i = 1'b1;
      @(negedge clk_100M);
      exp_uf = 1'b0;
      run_pixels("restart", F_PIX);
   endtask

`ifdef VGA_TESTPAT_EN
   task automatic test_pattern();
      tp_on = 1'b1;
      test_mode = 1'b1;
      force_h = 2;
      force_v = 1;
      #1;
      run_pixels("testpat", F_PIX);
      tp_on = 1'b0;
      test_mode = 1'b0;
      force_h = -1;
      force_v = -1;
      #1;
      run_pixels("after_tp", H_TOT);
   endtask
`endif

   initial begin
      for (int i = 1; i <= 600; i++) fifo_q.push_back(16'(i));
      test_reset();
      test_raster();
      test_underflow();
      test_reset_midframe();
`ifdef VGA_TESTPAT_EN
      test_pattern();
`endif
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
